// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares one regfile write port (p0) and one ROB completion port among the
// ALU (0), VALU (1) and MDU (2). Each unit pushes completions into a private
// FIFO; a round-robin scheduler presents and pops one head per cycle, so
// simultaneous completions are queued and back-pressured instead of lost.
module wb_port_arbiter #(
    parameter int DEPTH = 2  // entries per requester FIFO, power of two, >= 2
) (
    input  logic        cpu_clock_i,
    input  logic        cpu_reset_i,
    input  logic        flush_i,

    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [31:0] alu_result_i,
    input  logic [5:0]  alu_dest_i,
    input  logic        alu_wb_valid_i,
    input  logic [4:0]  alu_rob_id_i,

    input  logic        valu_valid_i,
    output logic        valu_ready_o,
    input  logic [31:0] valu_result_i,
    input  logic [5:0]  valu_dest_i,
    input  logic        valu_wb_valid_i,
    input  logic [4:0]  valu_rob_id_i,

    input  logic        mdu_valid_i,
    output logic        mdu_ready_o,
    input  logic [31:0] mdu_result_i,
    input  logic [5:0]  mdu_dest_i,
    input  logic        mdu_wb_valid_i,
    input  logic [4:0]  mdu_rob_id_i,

    output logic [31:0] p0_we_data,
    output logic [5:0]  p0_we_dest,
    output logic        p0_wen,
    output logic [4:0]  rob_id_o,
    output logic        rob_valid
);

    localparam int NREQ  = 3;
    localparam int PTR_W = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the index bits match.
    typedef logic [PTR_W:0] ptr_t;

    typedef struct packed {
        logic [31:0] result;
        logic [5:0]  dest;
        logic        wb_valid;
        logic [4:0]  rob_id;
    } entry_t;

    // Round-robin successor over the three requesters (0 -> 1 -> 2 -> 0).
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    entry_t          mem_q    [NREQ][DEPTH];
    ptr_t            wr_ptr_q [NREQ];
    ptr_t            wr_ptr_d [NREQ];
    ptr_t            rd_ptr_q [NREQ];
    ptr_t            rd_ptr_d [NREQ];
    logic [1:0]      rr_ptr_q;
    logic [1:0]      rr_ptr_d;

    entry_t          in_entry [NREQ];
    logic [NREQ-1:0] in_valid;
    logic [NREQ-1:0] empty;
    logic [NREQ-1:0] full;
    logic [NREQ-1:0] push;
    logic [NREQ-1:0] pop;
    logic            grant_any;
    logic [1:0]      grant_idx;
    entry_t          head;
    logic            present;

    // Gather the three requester port sets into indexable arrays.
    always_comb begin
        in_valid    = {mdu_valid_i, valu_valid_i, alu_valid_i};
        in_entry[0] = {alu_result_i,  alu_dest_i,  alu_wb_valid_i,  alu_rob_id_i};
        in_entry[1] = {valu_result_i, valu_dest_i, valu_wb_valid_i, valu_rob_id_i};
        in_entry[2] = {mdu_result_i,  mdu_dest_i,  mdu_wb_valid_i,  mdu_rob_id_i};
    end

    // FIFO occupancy flags, derived from registered pointers only.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]  = (wr_ptr_q[i][PTR_W] != rd_ptr_q[i][PTR_W]) &&
                       (wr_ptr_q[i][PTR_W-1:0] == rd_ptr_q[i][PTR_W-1:0]);
        end
    end

    // Ready never looks at same-cycle pop, so a full FIFO stays not-ready while popping.
    assign alu_ready_o  = ~full[0];
    assign valu_ready_o = ~full[1];
    assign mdu_ready_o  = ~full[2];

    // Round-robin grant: first non-empty FIFO at or after rr_ptr.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        logic [1:0] cand;
        cand      = rr_ptr_q;
        grant_any = 1'b0;
        grant_idx = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && !empty[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
            cand = rr_next(cand);
        end
    end

    // Present the granted head; flush and reset gate the whole port to zero.
    always_comb begin
        head       = mem_q[grant_idx][rd_ptr_q[grant_idx][PTR_W-1:0]];
        present    = grant_any & ~flush_i & ~cpu_reset_i;
        rob_valid  = present;
        p0_wen     = present & head.wb_valid;
        p0_we_data = present ? head.result : '0;
        p0_we_dest = present ? head.dest   : '0;
        rob_id_o   = present ? head.rob_id : '0;
    end

    // Next-state for pointers and the round-robin pointer.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            push[i]     = in_valid[i] & ~full[i] & ~flush_i;
            pop[i]      = grant_any & (grant_idx == 2'(i)) & ~flush_i;
            wr_ptr_d[i] = wr_ptr_q[i] + ptr_t'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + ptr_t'(pop[i]);
            if (flush_i) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
            end
        end
        if (grant_any && !flush_i) begin
            rr_ptr_d = rr_next(grant_idx);
        end
    end

    // Pointer and scheduler state, synchronous reset.
    always_ff @(posedge cpu_clock_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (cpu_reset_i) begin
            rr_ptr_q <= 2'd0;
            for (int i = 0; i < NREQ; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NREQ; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
        end
    end

    // Entry storage written on push.
    always_ff @(posedge cpu_clock_i) begin
        // NOTE: storage has no reset; the pointers alone decide which slots hold live entries.
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i][PTR_W-1:0]] <= in_entry[i];
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: one table row per clock cycle holds the
// inputs driven in that cycle and the outputs expected in that same cycle.
module tb_wb_port_arbiter;

    typedef struct packed {
        logic             rst;
        logic             flush;
        logic [2:0]       valid;
        logic [2:0][31:0] res;
        logic [2:0][5:0]  dest;
        logic [2:0]       wb;
        logic [2:0][4:0]  rob;
        logic             e_rv;
        logic             e_wen;
        logic [31:0]      e_data;
        logic [5:0]       e_dest;
        logic [4:0]       e_rob;
        logic [2:0]       e_rdy;   // {mdu, valu, alu}
    } vec_t;

    logic        clk;
    logic        cpu_reset_i;
    logic        flush_i;
    logic        alu_valid_i,  valu_valid_i,  mdu_valid_i;
    logic        alu_ready_o,  valu_ready_o,  mdu_ready_o;
    logic [31:0] alu_result_i, valu_result_i, mdu_result_i;
    logic [5:0]  alu_dest_i,   valu_dest_i,   mdu_dest_i;
    logic        alu_wb_valid_i, valu_wb_valid_i, mdu_wb_valid_i;
    logic [4:0]  alu_rob_id_i, valu_rob_id_i, mdu_rob_id_i;
    logic [31:0] p0_we_data;
    logic [5:0]  p0_we_dest;
    logic        p0_wen;
    logic [4:0]  rob_id_o;
    logic        rob_valid;

    int n_vec = 0;
    int n_bad = 0;

    wb_port_arbiter #(.DEPTH(2)) dut (
        .cpu_clock_i     (clk),
        .cpu_reset_i     (cpu_reset_i),
        .flush_i         (flush_i),
        .alu_valid_i     (alu_valid_i),
        .alu_ready_o     (alu_ready_o),
        .alu_result_i    (alu_result_i),
        .alu_dest_i      (alu_dest_i),
        .alu_wb_valid_i  (alu_wb_valid_i),
        .alu_rob_id_i    (alu_rob_id_i),
        .valu_valid_i    (valu_valid_i),
        .valu_ready_o    (valu_ready_o),
        .valu_result_i   (valu_result_i),
        .valu_dest_i     (valu_dest_i),
        .valu_wb_valid_i (valu_wb_valid_i),
        .valu_rob_id_i   (valu_rob_id_i),
        .mdu_valid_i     (mdu_valid_i),
        .mdu_ready_o     (mdu_ready_o),
        .mdu_result_i    (mdu_result_i),
        .mdu_dest_i      (mdu_dest_i),
        .mdu_wb_valid_i  (mdu_wb_valid_i),
        .mdu_rob_id_i    (mdu_rob_id_i),
        .p0_we_data      (p0_we_data),
        .p0_we_dest      (p0_we_dest),
        .p0_wen          (p0_wen),
        .rob_id_o        (rob_id_o),
        .rob_valid       (rob_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Idle row: no offers, no flush/reset, outputs zero, all FIFOs ready.
    function automatic vec_t vidle();
        vec_t t;
        t       = '0;
        t.e_rdy = 3'b111;
        return t;
    endfunction

    // Add an offer from requester r.
    function automatic vec_t off(vec_t t, int r, logic [31:0] d, logic [5:0] dst, logic wb, logic [4:0] rb);
        t.valid[r] = 1'b1;
        t.res[r]   = d;
        t.dest[r]  = dst;
        t.wb[r]    = wb;
        t.rob[r]   = rb;
        return t;
    endfunction

    // Expect a completion on the shared port this cycle.
    function automatic vec_t ex(vec_t t, logic [31:0] d, logic [5:0] dst, logic wb, logic [4:0] rb);
        t.e_rv   = 1'b1;
        t.e_wen  = wb;
        t.e_data = d;
        t.e_dest = dst;
        t.e_rob  = rb;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        cpu_reset_i     = t.rst;
        flush_i         = t.flush;
        alu_valid_i     = t.valid[0];
        alu_result_i    = t.res[0];
        alu_dest_i      = t.dest[0];
        alu_wb_valid_i  = t.wb[0];
        alu_rob_id_i    = t.rob[0];
        valu_valid_i    = t.valid[1];
        valu_result_i   = t.res[1];
        valu_dest_i     = t.dest[1];
        valu_wb_valid_i = t.wb[1];
        valu_rob_id_i   = t.rob[1];
        mdu_valid_i     = t.valid[2];
        mdu_result_i    = t.res[2];
        mdu_dest_i      = t.dest[2];
        mdu_wb_valid_i  = t.wb[2];
        mdu_rob_id_i    = t.rob[2];
    endtask

    task automatic check(input vec_t t, input string name);
        logic [2:0] rdy;
        rdy = {mdu_ready_o, valu_ready_o, alu_ready_o};
        n_vec++;
        if (rob_valid !== t.e_rv || p0_wen !== t.e_wen || p0_we_data !== t.e_data ||
            p0_we_dest !== t.e_dest || rob_id_o !== t.e_rob || rdy !== t.e_rdy) begin
            n_bad++;
            $display("FAIL %s: got rv=%b wen=%b data=%h dest=%0d rob=%0d rdy=%b, expected rv=%b wen=%b data=%h dest=%0d rob=%0d rdy=%b",
                     name, rob_valid, p0_wen, p0_we_data, p0_we_dest, rob_id_o, rdy,
                     t.e_rv, t.e_wen, t.e_data, t.e_dest, t.e_rob, t.e_rdy);
        end
    endtask

    vec_t tbl[$];
    vec_t t;

    initial begin
        // ---- single ALU push, one-cycle latency, then idle
        t = vidle(); t = off(t, 0, 32'hDEADBEEF, 6'd12, 1'b1, 5'd3); tbl.push_back(t);
        t = vidle(); t = ex(t, 32'hDEADBEEF, 6'd12, 1'b1, 5'd3); tbl.push_back(t);
        t = vidle(); tbl.push_back(t);
        // ---- lone MDU completion moves rr_ptr from 1 to 0
        t = vidle(); t = off(t, 2, 32'hCAFE0001, 6'd33, 1'b1, 5'd9); tbl.push_back(t);
        t = vidle(); t = ex(t, 32'hCAFE0001, 6'd33, 1'b1, 5'd9); tbl.push_back(t);
        // ---- three simultaneous pushes with rr_ptr=0 drain ALU, VALU, MDU
        t = vidle();
        t = off(t, 0, 32'h11111111, 6'd1, 1'b1, 5'd1);
        t = off(t, 1, 32'h22222222, 6'd2, 1'b1, 5'd2);
        t = off(t, 2, 32'h33333333, 6'd3, 1'b1, 5'd4); tbl.push_back(t);
        t = vidle(); t = ex(t, 32'h11111111, 6'd1, 1'b1, 5'd1); tbl.push_back(t);
        t = vidle(); t = ex(t, 32'h22222222, 6'd2, 1'b1, 5'd2); tbl.push_back(t);
        t = vidle(); t = ex(t, 32'h33333333, 6'd3, 1'b1, 5'd4); tbl.push_back(t);
        t = vidle(); tbl.push_back(t);
        // ---- VALU entry without regfile write: rob_valid only (rr_ptr 0 -> 2)
        t = vidle(); t = off(t, 1, 32'h44444444, 6'd5, 1'b0, 5'd17); tbl.push_back(t);
        t = vidle(); t = ex(t, 32'h44444444, 6'd5, 1'b0, 5'd17); tbl.push_back(t);
        t = vidle(); tbl.push_back(t);
        // ---- ALU and VALU continuously offering; producers hold an entry until accepted
        t = vidle(); t = off(t, 0, 32'hA0000000, 6'd10, 1'b1, 5'd0);
                     t = off(t, 1, 32'hB0000000, 6'd20, 1'b1, 5'd10); tbl.push_back(t);
        t = vidle(); t = off(t, 0, 32'hA0000001, 6'd11, 1'b1, 5'd1);
                     t = off(t, 1, 32'hB0000001, 6'd21, 1'b1, 5'd11);
                     t = ex(t, 32'hA0000000, 6'd10, 1'b1, 5'd0); tbl.push_back(t);
        t = vidle(); t = off(t, 0, 32'hA0000002, 6'd12, 1'b1, 5'd2);
                     t = off(t, 1, 32'hB0000002, 6'd22, 1'b1, 5'd12);
                     t = ex(t, 32'hB0000000, 6'd20, 1'b1, 5'd10); t.e_rdy = 3'b101; tbl.push_back(t);
        t = vidle(); t = off(t, 0, 32'hA0000003, 6'd13, 1'b1, 5'd3);
                     t = off(t, 1, 32'hB0000002, 6'd22, 1'b1, 5'd12);
                     t = ex(t, 32'hA0000001, 6'd11, 1'b1, 5'd1); t.e_rdy = 3'b110; tbl.push_back(t);
        t = vidle(); t = off(t, 0, 32'hA0000003, 6'd13, 1'b1, 5'd3);
                     t = off(t, 1, 32'hB0000003, 6'd23, 1'b1, 5'd13);
                     t = ex(t, 32'hB0000001, 6'd21, 1'b1, 5'd11); t.e_rdy = 3'b101; tbl.push_back(t);
        t = vidle(); t = off(t, 0, 32'hA0000004, 6'd14, 1'b1, 5'd4);
                     t = off(t, 1, 32'hB0000003, 6'd23, 1'b1, 5'd13);
                     t = ex(t, 32'hA0000002, 6'd12, 1'b1, 5'd2); t.e_rdy = 3'b110; tbl.push_back(t);
        t = vidle(); t = ex(t, 32'hB0000002, 6'd22, 1'b1, 5'd12); t.e_rdy = 3'b101; tbl.push_back(t);
        t = vidle(); t = ex(t, 32'hA0000003, 6'd13, 1'b1, 5'd3); tbl.push_back(t);
        t = vidle(); t = ex(t, 32'hB0000003, 6'd23, 1'b1, 5'd13); tbl.push_back(t);
        t = vidle(); tbl.push_back(t);
        // ---- fill, flush with rr_ptr=1, pushes during flush dropped, rr_ptr kept
        t = vidle(); t = off(t, 0, 32'hC0000000, 6'd30, 1'b1, 5'd20);
                     t = off(t, 1, 32'hD0000000, 6'd40, 1'b1, 5'd24);
                     t = off(t, 2, 32'hE0000000, 6'd50, 1'b1, 5'd28); tbl.push_back(t);
        t = vidle(); t = off(t, 0, 32'hC0000001, 6'd31, 1'b1, 5'd21);
                     t = off(t, 1, 32'hD0000001, 6'd41, 1'b1, 5'd25);
                     t = off(t, 2, 32'hE0000001, 6'd51, 1'b1, 5'd29);
                     t = ex(t, 32'hE0000000, 6'd50, 1'b1, 5'd28); tbl.push_back(t);
        t = vidle(); t = ex(t, 32'hC0000000, 6'd30, 1'b1, 5'd20); t.e_rdy = 3'b100; tbl.push_back(t);
        t = vidle(); t.flush = 1'b1;
                     t = off(t, 0, 32'hC0000002, 6'd32, 1'b1, 5'd22);
                     t = off(t, 2, 32'hE0000002, 6'd52, 1'b1, 5'd30); t.e_rdy = 3'b101; tbl.push_back(t);
        t = vidle(); tbl.push_back(t);
        t = vidle(); t = off(t, 0, 32'hF00D0000, 6'd60, 1'b1, 5'd5);
                     t = off(t, 1, 32'hF00D0001, 6'd61, 1'b1, 5'd6);
                     t = off(t, 2, 32'hF00D0002, 6'd62, 1'b1, 5'd7); tbl.push_back(t);
        t = vidle(); t = ex(t, 32'hF00D0001, 6'd61, 1'b1, 5'd6); tbl.push_back(t);
        t = vidle(); t = ex(t, 32'hF00D0002, 6'd62, 1'b1, 5'd7); tbl.push_back(t);
        t = vidle(); t = ex(t, 32'hF00D0000, 6'd60, 1'b1, 5'd5); tbl.push_back(t);
        t = vidle(); tbl.push_back(t);
        // ---- reset with two entries queued: nothing emitted, rr_ptr back to 0
        t = vidle(); t = off(t, 0, 32'h55550000, 6'd7, 1'b1, 5'd11);
                     t = off(t, 1, 32'h66660000, 6'd8, 1'b1, 5'd12); tbl.push_back(t);
        t = vidle(); t.rst = 1'b1; tbl.push_back(t);
        t = vidle(); tbl.push_back(t);
        t = vidle(); t = off(t, 0, 32'h77770000, 6'd13, 1'b1, 5'd13);
                     t = off(t, 1, 32'h77770001, 6'd14, 1'b1, 5'd14);
                     t = off(t, 2, 32'h77770002, 6'd15, 1'b1, 5'd15); tbl.push_back(t);
        t = vidle(); t = ex(t, 32'h77770000, 6'd13, 1'b1, 5'd13); tbl.push_back(t);
        t = vidle(); t = ex(t, 32'h77770001, 6'd14, 1'b1, 5'd14); tbl.push_back(t);
        t = vidle(); t = ex(t, 32'h77770002, 6'd15, 1'b1, 5'd15); tbl.push_back(t);
        t = vidle(); tbl.push_back(t);

        // ---- power-on reset held two cycles: outputs zero while asserted
        t = vidle(); t.rst = 1'b1;
        drive(t);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check(t, "reset_hold");
        @(posedge clk);
        #1;
        // ---- first cycle after release: idle port, every FIFO ready
        t = vidle();
        drive(t);
        @(negedge clk);
        check(t, "after_reset");
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check(tbl[i], $sformatf("vec%0d", i));
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
